rob_queue: RTL and testbench

ROB_QUEUE -- requirements
Module: rob_queue

---
 rtl/rob_queue.sv | 233 +++++++++++++++++++++++
 tb/tb_rob_queue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_queue.sv
// ---------------------------------------------------------------------------
// rob_queue -- circular reorder buffer with dual-slot allocate, dual writeback
// and in-order dual commit.
//
// Entries are allocated at the tail and retired from the head, in order.
// An entry can retire once it has been written back. The head entry and the
// entry after it can retire in the same cycle.
//
// Parameters
//   WIDTH  payload width in bits
//   ADDR   index width; DEPTH = 1 << ADDR is derived and cannot be overridden
//
// Ports
//   clk                  single clock, rising edge
//   reset                synchronous, active-low; takes priority over all else
//   flush                synchronous discard of every entry
//   alloc_req_0/1        dispatch slot requests (slot 1 needs slot 0 accepted)
//   alloc_ready_0/1      slot may allocate this cycle (registered count only)
//   alloc_idx_0/1        index granted to slot 0 / slot 1 (tail, tail+1)
//   wb_en_0/1            writeback strobes
//   wb_idx_0/1           writeback entry index
//   wb_data_0/1          writeback payload (port 1 wins on an index clash)
//   commit_ready         consumer accepts commits this cycle
//   commit_valid_0/1     head / head+1 ready to retire
//   commit_data_0/1      payload of head / head+1
//   count                occupied entries (ADDR+1 bits)
//   empty, full          occupancy flags
//
// Optional feature, enabled by defining ROB_QUEUE_RD_PORTS_EN:
//   rd_en_0/1, rd_idx_0/1  operand read requests
//   rd_data_0/1            registered payload, held while rd_en is low
//   rd_done_0/1            registered done bit of the read entry
//   A writeback to the read index in the same cycle is forwarded.
// ---------------------------------------------------------------------------
module rob_queue #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_req_0,
    input  logic             alloc_req_1,
    output logic             alloc_ready_0,
    output logic             alloc_ready_1,
    output logic [ADDR-1:0]  alloc_idx_0,
    output logic [ADDR-1:0]  alloc_idx_1,
    input  logic             wb_en_0,
    input  logic             wb_en_1,
    input  logic [ADDR-1:0]  wb_idx_0,
    input  logic [ADDR-1:0]  wb_idx_1,
    input  logic [WIDTH-1:0] wb_data_0,
    input  logic [WIDTH-1:0] wb_data_1,
    input  logic             commit_ready,
    output logic             commit_valid_0,
    output logic             commit_valid_1,
    output logic [WIDTH-1:0] commit_data_0,
    output logic [WIDTH-1:0] commit_data_1,
`ifdef ROB_QUEUE_RD_PORTS_EN
    input  logic             rd_en_0,
    input  logic             rd_en_1,
    input  logic [ADDR-1:0]  rd_idx_0,
    input  logic [ADDR-1:0]  rd_idx_1,
    output logic [WIDTH-1:0] rd_data_0,
    output logic [WIDTH-1:0] rd_data_1,
    output logic             rd_done_0,
    output logic             rd_done_1,
`endif
    output logic [ADDR:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << ADDR;
    localparam logic [ADDR:0] CNT_FULL  = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] CNT_ROOM1 = (ADDR+1)'(DEPTH - 1);
    localparam logic [ADDR:0] CNT_ROOM2 = (ADDR+1)'(DEPTH - 2);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [ADDR-1:0]  head_q;
    logic [ADDR-1:0]  tail_q;
    logic [ADDR:0]    count_q;

    logic [ADDR-1:0]  head_nx1;
    logic [ADDR-1:0]  tail_nx1;
    logic             acc_0;
    logic             acc_1;
    logic             ret_0;
    logic             ret_1;
    logic             wb_ok_0;
    logic             wb_ok_1;
    logic [ADDR:0]    n_alloc;
    logic [ADDR:0]    n_ret;

    // ------------------------------------------------------------------
    // Combinational view of the registered state
    // ------------------------------------------------------------------
    assign head_nx1 = head_q + ADDR'(1);
    assign tail_nx1 = tail_q + ADDR'(1);

    assign alloc_idx_0   = tail_q;
    assign alloc_idx_1   = tail_nx1;
    assign alloc_ready_0 = (count_q <= CNT_ROOM1);
    assign alloc_ready_1 = (count_q <= CNT_ROOM2);

    // Slot 1 only rides along with an accepted slot 0, so allocations stay
    // contiguous at the tail.
    assign acc_0 = alloc_req_0 & alloc_ready_0;
    assign acc_1 = acc_0 & alloc_req_1 & alloc_ready_1;

    // Writebacks to entries that are not allocated are dropped.
    assign wb_ok_0 = wb_en_0 & valid_q[wb_idx_0];
    assign wb_ok_1 = wb_en_1 & valid_q[wb_idx_1];

    assign commit_valid_0 = valid_q[head_q] & done_q[head_q];
    assign commit_valid_1 = commit_valid_0 & valid_q[head_nx1] & done_q[head_nx1];
    assign commit_data_0  = data_q[head_q];
    assign commit_data_1  = data_q[head_nx1];

    assign ret_0 = commit_ready & commit_valid_0;
    assign ret_1 = commit_ready & commit_valid_1;

    assign n_alloc = (ADDR+1)'(acc_0) + (ADDR+1)'(acc_1);
    assign n_ret   = (ADDR+1)'(ret_0) + (ADDR+1)'(ret_1);

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // ------------------------------------------------------------------
    // Control state: valid/done bits, pointers, occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: several non-blocking writes may hit the same bit below;
            // the last one in program order takes effect, which is how port 1
            // beats port 0 on a writeback index clash.
            if (wb_ok_0) done_q[wb_idx_0] <= 1'b1;
            if (wb_ok_1) done_q[wb_idx_1] <= 1'b1;

            // Allocated entries are always free, so these never collide with
            // the writebacks above or the retires below.
            if (acc_0) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
            end
            if (acc_1) begin
                valid_q[tail_nx1] <= 1'b1;
                done_q[tail_nx1]  <= 1'b0;
            end

            if (ret_0) valid_q[head_q]   <= 1'b0;
            if (ret_1) valid_q[head_nx1] <= 1'b0;

            head_q  <= head_q + n_ret[ADDR-1:0];
            tail_q  <= tail_q + n_alloc[ADDR-1:0];
            count_q <= count_q + n_alloc - n_ret;
        end
    end

    // ------------------------------------------------------------------
    // Payload storage
    // ------------------------------------------------------------------
    // NOTE: the payload array is deliberately left out of reset; an entry's
    // data is only observed once its done bit is set by a writeback.
    always_ff @(posedge clk) begin
        if (reset && !flush) begin
            if (wb_ok_0) data_q[wb_idx_0] <= wb_data_0;
            if (wb_ok_1) data_q[wb_idx_1] <= wb_data_1;
        end
    end

`ifdef ROB_QUEUE_RD_PORTS_EN
    // ------------------------------------------------------------------
    // Operand read ports with same-cycle writeback forwarding
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rd_fwd_data_0;
    logic [WIDTH-1:0] rd_fwd_data_1;
    logic             rd_fwd_done_0;
    logic             rd_fwd_done_1;

    always_comb begin
        rd_fwd_data_0 = data_q[rd_idx_0];
        rd_fwd_done_0 = done_q[rd_idx_0];
        rd_fwd_data_1 = data_q[rd_idx_1];
        rd_fwd_done_1 = done_q[rd_idx_1];
        // Port 1 is checked last so it wins, matching the array write order.
        if (wb_ok_0 && wb_idx_0 == rd_idx_0) begin
            rd_fwd_data_0 = wb_data_0;
            rd_fwd_done_0 = 1'b1;
        end
        if (wb_ok_1 && wb_idx_1 == rd_idx_0) begin
            rd_fwd_data_0 = wb_data_1;
            rd_fwd_done_0 = 1'b1;
        end
        if (wb_ok_0 && wb_idx_0 == rd_idx_1) begin
            rd_fwd_data_1 = wb_data_0;
            rd_fwd_done_1 = 1'b1;
        end
        if (wb_ok_1 && wb_idx_1 == rd_idx_1) begin
            rd_fwd_data_1 = wb_data_1;
            rd_fwd_done_1 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_0 <= '0;
            rd_done_0 <= 1'b0;
            rd_data_1 <= '0;
            rd_done_1 <= 1'b0;
        end else begin
            if (rd_en_0) begin
                rd_data_0 <= rd_fwd_data_0;
                rd_done_0 <= rd_fwd_done_0;
            end
            if (rd_en_1) begin
                rd_data_1 <= rd_fwd_data_1;
                rd_done_1 <= rd_fwd_done_1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_queue.sv
// ---------------------------------------------------------------------------
// tb_rob_queue -- directed, self-checking bench for rob_queue (WIDTH=8,
// ADDR=4, DEPTH=16). Allocated indices are queued in program order as they
// are granted; writebacks update a reference payload table; every retire pops
// the oldest index and compares the committed payload with the table.
// Occupancy is tracked by a separate model count.
// ---------------------------------------------------------------------------
module tb_rob_queue;
    localparam int WIDTH = 8;
    localparam int ADDR  = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             alloc_req_0 = 1'b0;
    logic             alloc_req_1 = 1'b0;
    logic             alloc_ready_0;
    logic             alloc_ready_1;
    logic [ADDR-1:0]  alloc_idx_0;
    logic [ADDR-1:0]  alloc_idx_1;
    logic             wb_en_0 = 1'b0;
    logic             wb_en_1 = 1'b0;
    logic [ADDR-1:0]  wb_idx_0 = '0;
    logic [ADDR-1:0]  wb_idx_1 = '0;
    logic [WIDTH-1:0] wb_data_0 = '0;
    logic [WIDTH-1:0] wb_data_1 = '0;
    logic             commit_ready = 1'b0;
    logic             commit_valid_0;
    logic             commit_valid_1;
    logic [WIDTH-1:0] commit_data_0;
    logic [WIDTH-1:0] commit_data_1;
    logic [ADDR:0]    count;
    logic             empty;
    logic             full;
`ifdef ROB_QUEUE_RD_PORTS_EN
    logic             rd_en_0 = 1'b0;
    logic             rd_en_1 = 1'b0;
    logic [ADDR-1:0]  rd_idx_0 = '0;
    logic [ADDR-1:0]  rd_idx_1 = '0;
    logic [WIDTH-1:0] rd_data_0;
    logic [WIDTH-1:0] rd_data_1;
    logic             rd_done_0;
    logic             rd_done_1;
`endif

    rob_queue #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .alloc_req_0    (alloc_req_0),
        .alloc_req_1    (alloc_req_1),
        .alloc_ready_0  (alloc_ready_0),
        .alloc_ready_1  (alloc_ready_1),
        .alloc_idx_0    (alloc_idx_0),
        .alloc_idx_1    (alloc_idx_1),
        .wb_en_0        (wb_en_0),
        .wb_en_1        (wb_en_1),
        .wb_idx_0       (wb_idx_0),
        .wb_idx_1       (wb_idx_1),
        .wb_data_0      (wb_data_0),
        .wb_data_1      (wb_data_1),
        .commit_ready   (commit_ready),
        .commit_valid_0 (commit_valid_0),
        .commit_valid_1 (commit_valid_1),
        .commit_data_0  (commit_data_0),
        .commit_data_1  (commit_data_1),
`ifdef ROB_QUEUE_RD_PORTS_EN
        .rd_en_0        (rd_en_0),
        .rd_en_1        (rd_en_1),
        .rd_idx_0       (rd_idx_0),
        .rd_idx_1       (rd_idx_1),
        .rd_data_0      (rd_data_0),
        .rd_data_1      (rd_data_1),
        .rd_done_0      (rd_done_0),
        .rd_done_1      (rd_done_1),
`endif
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [WIDTH-1:0] exp_data [DEPTH];
    int              sb_idx [$];
    logic [ADDR-1:0] m_tail  = '0;
    int              m_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(m_count));
        check({tag, "_empty"}, 32'(empty), 32'(m_count == 0));
        check({tag, "_full"},  32'(full),  32'(m_count == DEPTH));
    endtask

    task automatic model_clear();
        sb_idx.delete();
        m_tail  = '0;
        m_count = 0;
    endtask

    // Allocate n (1 or 2) entries that the queue is expected to accept.
    task automatic alloc(input int n);
        logic [ADDR-1:0] nxt;
        nxt = m_tail + ADDR'(1);
        alloc_req_0 = 1'b1;
        alloc_req_1 = (n == 2);
        check("alloc_idx_0", 32'(alloc_idx_0), 32'(m_tail));
        sb_idx.push_back(int'(m_tail));
        if (n == 2) begin
            check("alloc_idx_1", 32'(alloc_idx_1), 32'(nxt));
            sb_idx.push_back(int'(nxt));
        end
        tick();
        alloc_req_0 = 1'b0;
        alloc_req_1 = 1'b0;
        m_tail  = m_tail + ADDR'(n);
        m_count = m_count + n;
    endtask

    // Writeback to allocated entries; port 1 is applied last in the model.
    task automatic wb(input logic [ADDR-1:0] i0, input logic [WIDTH-1:0] d0,
                      input logic e1, input logic [ADDR-1:0] i1, input logic [WIDTH-1:0] d1);
        wb_en_0 = 1'b1; wb_idx_0 = i0; wb_data_0 = d0;
        wb_en_1 = e1;   wb_idx_1 = i1; wb_data_1 = d1;
        tick();
        wb_en_0 = 1'b0;
        wb_en_1 = 1'b0;
        exp_data[i0] = d0;
        if (e1) exp_data[i1] = d1;
    endtask

    // Retire with commit_ready=1, expecting exactly n entries to be ready.
    task automatic commit(input int n);
        check("commit_valid_0", 32'(commit_valid_0), 32'(n >= 1));
        check("commit_valid_1", 32'(commit_valid_1), 32'(n == 2));
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = sb_idx.pop_front();
            check($sformatf("commit_data_%0d_idx%0d", k, idx),
                  32'((k == 0) ? commit_data_0 : commit_data_1), 32'(exp_data[idx]));
        end
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        m_count = m_count - n;
        check_state("after_commit");
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check_state("in_reset");
        check("in_reset_ready_0", 32'(alloc_ready_0), 32'd1);
        check("in_reset_ready_1", 32'(alloc_ready_1), 32'd1);
        check("in_reset_cv_0", 32'(commit_valid_0), 32'd0);
        check("in_reset_cv_1", 32'(commit_valid_1), 32'd0);
`ifdef ROB_QUEUE_RD_PORTS_EN
        check("in_reset_rd_data_0", 32'(rd_data_0), 32'd0);
        check("in_reset_rd_done_1", 32'(rd_done_1), 32'd0);
`endif
        reset = 1'b1;
        tick();
        check_state("after_reset");

        // ---------------- fill with paired allocations ----------------
        for (int i = 0; i < 8; i++) alloc(2);
        check_state("filled");
        check("filled_ready_0", 32'(alloc_ready_0), 32'd0);
        check("filled_ready_1", 32'(alloc_ready_1), 32'd0);

        // ---------------- out-of-order writeback, dual retire ----------------
        wb(4'd1, 8'h11, 1'b0, 4'd0, 8'h00);
        check("head_not_done_cv_0", 32'(commit_valid_0), 32'd0);
        check("head_not_done_cv_1", 32'(commit_valid_1), 32'd0);
        wb(4'd0, 8'h10, 1'b0, 4'd0, 8'h00);
        commit(2);

        // ---------------- full: retire one while allocating ----------------
        alloc(2);
        check_state("refilled");
        wb(4'd2, 8'h12, 1'b0, 4'd0, 8'h00);
        check("full_cv_0", 32'(commit_valid_0), 32'd1);
        check("full_cv_1", 32'(commit_valid_1), 32'd0);
        check("full_ready_0", 32'(alloc_ready_0), 32'd0);
        begin
            int idx;
            idx = sb_idx.pop_front();
            check("full_commit_data", 32'(commit_data_0), 32'(exp_data[idx]));
        end
        alloc_req_0  = 1'b1;
        commit_ready = 1'b1;
        tick();
        alloc_req_0  = 1'b0;
        commit_ready = 1'b0;
        m_count = m_count - 1;
        check_state("full_alloc_rejected");
        check("full_tail_held", 32'(alloc_idx_0), 32'(m_tail));

        // ---------------- flush ----------------
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        check_state("after_flush");
        check("after_flush_cv_0", 32'(commit_valid_0), 32'd0);
        check("after_flush_tail", 32'(alloc_idx_0), 32'd0);

        // ---------------- writeback collision and stray writeback ----------------
        for (int i = 0; i < 5; i++) alloc(1);
        wb(4'd3, 8'hAA, 1'b1, 4'd3, 8'h55);
        wb_en_0 = 1'b1; wb_idx_0 = 4'd9; wb_data_0 = 8'hEE;
        tick();
        wb_en_0 = 1'b0;
        check_state("stray_wb");
        check("stray_wb_cv_0", 32'(commit_valid_0), 32'd0);
        for (int i = 0; i < 10; i++) alloc(1);
        wb(4'd0, 8'h30, 1'b1, 4'd1, 8'h31);
        commit(2);

        // ---------------- tail wrap (tail=15, head=2) ----------------
        check("pre_wrap_tail", 32'(alloc_idx_0), 32'd15);
        alloc(2);
        check("post_wrap_tail", 32'(alloc_idx_0), 32'd1);
        check_state("post_wrap");
        wb(4'd2, 8'h32, 1'b0, 4'd0, 8'h00);
        commit(2);

        // ---------------- drain to 10 entries, flush with other activity ----------------
        wb(4'd4, 8'h44, 1'b1, 4'd5, 8'h45);
        commit(2);
        wb(4'd6, 8'h46, 1'b0, 4'd0, 8'h00);
        commit(1);
        flush = 1'b1;
        alloc_req_0 = 1'b1; alloc_req_1 = 1'b1;
        commit_ready = 1'b1;
        wb_en_0 = 1'b1; wb_idx_0 = 4'd7; wb_data_0 = 8'h77;
        tick();
        flush = 1'b0;
        alloc_req_0 = 1'b0; alloc_req_1 = 1'b0;
        commit_ready = 1'b0;
        wb_en_0 = 1'b0;
        model_clear();
        check_state("busy_flush");
        check("busy_flush_cv_0", 32'(commit_valid_0), 32'd0);
        check("busy_flush_tail", 32'(alloc_idx_0), 32'd0);

        // ---------------- reset in the middle of an allocation burst ----------------
        alloc(2);
        alloc(2);
        alloc_req_0 = 1'b1; alloc_req_1 = 1'b1;
        commit_ready = 1'b1;
        reset = 1'b0;
        tick();
        model_clear();
        check_state("mid_burst_reset");
        check("mid_burst_ready_0", 32'(alloc_ready_0), 32'd1);
        check("mid_burst_ready_1", 32'(alloc_ready_1), 32'd1);
        check("mid_burst_cv_0", 32'(commit_valid_0), 32'd0);
        check("mid_burst_cv_1", 32'(commit_valid_1), 32'd0);
        tick();
        reset = 1'b1;
        alloc_req_0 = 1'b0; alloc_req_1 = 1'b0;
        commit_ready = 1'b0;
        tick();
        check_state("post_reset");

        // ---------------- single entry round trip (read ports if present) ----------------
        alloc(1);
`ifdef ROB_QUEUE_RD_PORTS_EN
        rd_en_0 = 1'b1; rd_idx_0 = 4'd0;
        wb(4'd0, 8'h5A, 1'b0, 4'd0, 8'h00);
        rd_en_0 = 1'b0;
        check("rd_fwd_data_0", 32'(rd_data_0), 32'h5A);
        check("rd_fwd_done_0", 32'(rd_done_0), 32'd1);
        rd_en_1 = 1'b1; rd_idx_1 = 4'd0;
        wb(4'd0, 8'h3C, 1'b1, 4'd0, 8'hC3);
        rd_en_1 = 1'b0;
        check("rd_hold_data_0", 32'(rd_data_0), 32'h5A);
        check("rd_fwd_data_1", 32'(rd_data_1), 32'hC3);
        check("rd_fwd_done_1", 32'(rd_done_1), 32'd1);
`else
        wb(4'd0, 8'hC3, 1'b0, 4'd0, 8'h00);
`endif
        commit(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
